ufifo_txuart: RTL

//  Read side of the UART transmit path: drains bytes from a ufifo-style FIFO
//  and serializes them onto the serial line, LSB first. Frame: start, 8 data,

---
 rtl/ufifo_txuart.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/ufifo_txuart.sv
// rtl/ufifo_txuart.sv - UART transmitter draining a ufifo-style TX FIFO
module ufifo_txuart #(
    parameter int DIVW = 24
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [DIVW-1:0] i_baud_div,
    input  logic            i_parity_en,
    input  logic            i_parity_odd,
    input  logic            i_cts_n,
    input  logic            i_break,
    input  logic            i_empty_n,
    input  logic [7:0]      i_data,
    output logic            o_rd,
    output logic            o_uart_tx,
    output logic            o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DIVW-1:0] div_m1_q, div_m1_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [2:0]      bitidx_q, bitidx_d;
    logic            par_en_q, par_en_d;
    logic            par_bit_q, par_bit_d;
    logic            rel_q, rel_d;
    logic            tx_q, tx_d;
    logic            rd_q, rd_d;
    logic            busy_q, busy_d;

    logic [DIVW-1:0] eff_div;
    logic [DIVW-1:0] reload_in;
    logic            start_ok;
    logic            launch;

    // Divisor values below 2 are clamped so every bit spans at least two clocks.
    assign eff_div   = (i_baud_div < DIVW'(2)) ? DIVW'(2) : i_baud_div;
    assign reload_in = eff_div - DIVW'(1);
    assign start_ok  = i_empty_n && !i_cts_n && !i_break;

    assign o_rd      = rd_q;
    assign o_uart_tx = tx_q;
    assign o_busy    = busy_q;

    // State register and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_m1_q  <= '0;
            shreg_q   <= '0;
            bitidx_q  <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            rel_q     <= 1'b0;
            tx_q      <= 1'b1;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_m1_q  <= div_m1_d;
            shreg_q   <= shreg_d;
            bitidx_q  <= bitidx_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            rel_q     <= rel_d;
            tx_q      <= tx_d;
            rd_q      <= rd_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic; outputs are computed one cycle ahead so they leave registered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_m1_d  = div_m1_q;
        shreg_d   = shreg_q;
        bitidx_d  = bitidx_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        rel_d     = rel_q;
        tx_d      = tx_q;
        rd_d      = 1'b0;
        busy_d    = busy_q;
        launch    = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (start_ok) begin
                    launch = 1'b1;
                end else if (i_break) begin
                    state_d  = S_BREAK;
                    div_m1_d = reload_in;
                    rel_d    = 1'b0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_d  = S_DATA;
                    cnt_d    = div_m1_q;
                    bitidx_d = 3'd0;
                    tx_d     = shreg_q[0];
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_m1_q;
                    if (bitidx_q == 3'd7) begin
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bitidx_d = bitidx_q + 3'd1;
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        tx_d     = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == '0) begin
                    state_d = S_STOP;
                    cnt_d   = div_m1_q;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (start_ok) begin
                        launch = 1'b1;
                    end else if (i_break) begin
                        state_d = S_BREAK;
                        rel_d   = 1'b0;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
            end
            S_BREAK: begin
                if (!rel_q) begin
                    tx_d = 1'b0;
                    if (!i_break) begin
                        rel_d = 1'b1;
                        cnt_d = div_m1_q;
                        tx_d  = 1'b1;
                    end
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    rel_d   = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - DIVW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Character launch: latch the FIFO head and frame settings, pop once.
        if (launch) begin
            state_d   = S_START;
            shreg_d   = i_data;
            div_m1_d  = reload_in;
            cnt_d     = reload_in;
            par_en_d  = i_parity_en;
            par_bit_d = i_parity_odd ? ~^i_data : ^i_data;
            bitidx_d  = 3'd0;
            rd_d      = 1'b1;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end
    end

endmodule
